// File: rtl/video_timing_gen_if.sv
// Pixel-stream bundle between the timing generator and its consumer.
// The generator takes the master side; a sink or bench takes the slave side.
interface video_timing_gen_if #(
    parameter int CW = 12
);
    logic          ce;
    logic          resync;
    logic [1:0]    mode;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          de;
    logic          hsync;
    logic          vsync;
    logic [7:0]    red;
    logic [7:0]    green;
    logic [7:0]    blue;
    logic          sol;
    logic          sof;
    logic [15:0]   frame_cnt;

    modport master (
        input  ce, resync, mode,
        output x, y, de, hsync, vsync,
        output red, green, blue, sol, sof, frame_cnt
    );

    modport slave (
        output ce, resync, mode,
        input  x, y, de, hsync, vsync,
        input  red, green, blue, sol, sof, frame_cnt
    );
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator with sync, enable and test-pattern outputs.
// Every output is registered one ce-advance behind the internal counters.
module video_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CW       = 12
) (
    input  logic               clk,
    input  logic               reset,
    video_timing_gen_if.master vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] BAR_LAST = CW'(BAR_W - 1);

    if ((H_TOTAL - 1) >= (1 << CW) || (V_TOTAL - 1) >= (1 << CW)) begin : g_cw_err
        $error("CW cannot hold H_TOTAL-1 / V_TOTAL-1");
    end

    logic [CW-1:0] hc_q, hc_d, vc_q, vc_d;
    logic [CW-1:0] bpix_q, bpix_d;
    logic [2:0]    bar_q, bar_d;
    logic [1:0]    mode_q;
    logic [15:0]   frm_q, frm_d;

    logic [CW-1:0] x_q, y_q;
    logic          de_q, hs_q, vs_q, sol_q, sof_q;
    logic [23:0]   rgb_q;
    logic [15:0]   fc_q;

    logic          h_wrap, v_wrap;
    logic          de_c, hs_c, vs_c;
    logic [23:0]   rgb_c;

    assign h_wrap = (hc_q == H_LAST);
    assign v_wrap = (vc_q == V_LAST);

    always_comb begin
        hc_d   = h_wrap ? '0 : hc_q + 1'b1;
        vc_d   = vc_q;
        frm_d  = frm_q;
        bar_d  = bar_q;
        bpix_d = bpix_q;
        if (h_wrap) begin
            vc_d = v_wrap ? '0 : vc_q + 1'b1;
            if (v_wrap) frm_d = frm_q + 16'd1;
        end
        // Bar index tracks hc without a divider and sticks at the last bar.
        if (h_wrap) begin
            bar_d  = '0;
            bpix_d = '0;
        end else if (bar_q != 3'd7) begin
            if (bpix_q == BAR_LAST) begin
                bar_d  = bar_q + 3'd1;
                bpix_d = '0;
            end else begin
                bpix_d = bpix_q + 1'b1;
            end
        end
    end

    always_comb begin
        de_c  = (hc_q < H_ACT) && (vc_q < V_ACT);
        hs_c  = (hc_q >= HS_BEG && hc_q < HS_END) ? HS_POL : ~HS_POL;
        vs_c  = (vc_q >= VS_BEG && vc_q < VS_END) ? VS_POL : ~VS_POL;
        rgb_c = '0;
        unique case (mode_q)
            2'd0: rgb_c = '0;
            2'd1: rgb_c = {{8{~bar_q[1]}}, {8{~bar_q[2]}}, {8{~bar_q[0]}}};
            2'd2: rgb_c = {hc_q[7:0], vc_q[7:0], frm_q[7:0]};
            2'd3: rgb_c = (hc_q[4:0] == 5'd0 || vc_q[4:0] == 5'd0) ? '1 : '0;
        endcase
        if (!de_c) rgb_c = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hc_q   <= '0;
            vc_q   <= '0;
            bar_q  <= '0;
            bpix_q <= '0;
            mode_q <= '0;
            frm_q  <= '0;
            x_q    <= '0;
            y_q    <= '0;
            de_q   <= 1'b0;
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            rgb_q  <= '0;
            sol_q  <= 1'b0;
            sof_q  <= 1'b0;
            fc_q   <= '0;
        end else begin
            sol_q <= 1'b0;
            sof_q <= 1'b0;
            if (vif.resync) begin
                hc_q   <= '0;
                vc_q   <= '0;
                bar_q  <= '0;
                bpix_q <= '0;
                mode_q <= vif.mode;
            end else if (vif.ce) begin
                hc_q   <= hc_d;
                vc_q   <= vc_d;
                bar_q  <= bar_d;
                bpix_q <= bpix_d;
                frm_q  <= frm_d;
                if (h_wrap && v_wrap) mode_q <= vif.mode;
                x_q    <= hc_q;
                y_q    <= vc_q;
                de_q   <= de_c;
                hs_q   <= hs_c;
                vs_q   <= vs_c;
                rgb_q  <= rgb_c;
                sol_q  <= (hc_q == '0);
                sof_q  <= (hc_q == '0) && (vc_q == '0);
                fc_q   <= frm_q;
            end
        end
    end

    assign vif.x         = x_q;
    assign vif.y         = y_q;
    assign vif.de        = de_q;
    assign vif.hsync     = hs_q;
    assign vif.vsync     = vs_q;
    assign vif.red       = rgb_q[23:16];
    assign vif.green     = rgb_q[15:8];
    assign vif.blue      = rgb_q[7:0];
    assign vif.sol       = sol_q;
    assign vif.sof       = sof_q;
    assign vif.frame_cnt = fc_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// Two small-raster generators driven in lockstep and compared each cycle
// against a pixel-level model of the raster rules.
module tb_video_timing_gen;
    localparam int HA[2] = '{24, 21};
    localparam int HF[2] = '{2, 3};
    localparam int HS[2] = '{3, 4};
    localparam int HB[2] = '{3, 2};
    localparam int VA[2] = '{10, 9};
    localparam int VF[2] = '{1, 2};
    localparam int VS[2] = '{2, 1};
    localparam int VB[2] = '{2, 3};
    localparam bit HP[2] = '{1'b1, 1'b0};
    localparam bit VP[2] = '{1'b1, 1'b0};
    localparam bit [23:0] BARS[8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    typedef struct {
        int        x;
        int        y;
        bit        de;
        bit        hs;
        bit        vs;
        bit        sol;
        bit        sof;
        bit [23:0] rgb;
        bit [15:0] fc;
    } out_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    bit   rst_prev = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc_n = 0;

    int       mh[2], mv[2], mam[2];
    bit [15:0] mfrm[2];
    out_t     ex[2];

    video_timing_gen_if #(.CW(12)) if0 ();
    video_timing_gen_if #(.CW(12)) if1 ();

    video_timing_gen #(
        .H_ACTIVE(HA[0]), .H_FP(HF[0]), .H_SYNC(HS[0]), .H_BP(HB[0]),
        .V_ACTIVE(VA[0]), .V_FP(VF[0]), .V_SYNC(VS[0]), .V_BP(VB[0]),
        .HS_POL(HP[0]), .VS_POL(VP[0]), .CW(12)
    ) u_dut0 (.clk(clk), .reset(reset), .vif(if0));

    video_timing_gen #(
        .H_ACTIVE(HA[1]), .H_FP(HF[1]), .H_SYNC(HS[1]), .H_BP(HB[1]),
        .V_ACTIVE(VA[1]), .V_FP(VF[1]), .V_SYNC(VS[1]), .V_BP(VB[1]),
        .HS_POL(HP[1]), .VS_POL(VP[1]), .CW(12)
    ) u_dut1 (.clk(clk), .reset(reset), .vif(if1));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit [23:0] pattern(int am, int h, int v, int f);
        int b;
        case (am)
            1: begin
                b = h / (HA[0] == HA[0] ? 1 : 1);
                b = 0;
                return 24'h0;
            end
            default: return 24'h0;
        endcase
    endfunction

    function automatic bit [23:0] colour(int d, int am, int h, int v, int f);
        int b;
        case (am)
            1: begin
                b = h / (HA[d] / 8);
                if (b > 7) b = 7;
                return BARS[b];
            end
            2: return 24'((h % 256) * 65536 + (v % 256) * 256 + (f % 256));
            3: return (h % 32 == 0 || v % 32 == 0) ? 24'hFFFFFF : 24'h0;
            default: return 24'h0;
        endcase
    endfunction

    task automatic model_reset(input int d);
        mh[d] = 0;
        mv[d] = 0;
        mam[d] = 0;
        mfrm[d] = '0;
        ex[d].x = 0;
        ex[d].y = 0;
        ex[d].de = 1'b0;
        ex[d].hs = !HP[d];
        ex[d].vs = !VP[d];
        ex[d].sol = 1'b0;
        ex[d].sof = 1'b0;
        ex[d].rgb = '0;
        ex[d].fc = '0;
    endtask

    task automatic model_step(input int d, input bit r, input bit c,
                              input bit rs, input bit [1:0] m);
        int hs0, vs0;
        hs0 = HA[d] + HF[d];
        vs0 = VA[d] + VF[d];
        if (r) begin
            model_reset(d);
        end else if (rs) begin
            mh[d] = 0;
            mv[d] = 0;
            mam[d] = int'(m);
            ex[d].sol = 1'b0;
            ex[d].sof = 1'b0;
        end else if (c) begin
            ex[d].x = mh[d];
            ex[d].y = mv[d];
            ex[d].de = mh[d] < HA[d] && mv[d] < VA[d];
            ex[d].hs = (mh[d] >= hs0 && mh[d] < hs0 + HS[d]) ? HP[d] : !HP[d];
            ex[d].vs = (mv[d] >= vs0 && mv[d] < vs0 + VS[d]) ? VP[d] : !VP[d];
            ex[d].rgb = ex[d].de ? colour(d, mam[d], mh[d], mv[d], int'(mfrm[d])) : 24'h0;
            ex[d].sol = (mh[d] == 0);
            ex[d].sof = (mh[d] == 0 && mv[d] == 0);
            ex[d].fc = mfrm[d];
            mh[d]++;
            if (mh[d] == HA[d] + HF[d] + HS[d] + HB[d]) begin
                mh[d] = 0;
                mv[d]++;
                if (mv[d] == VA[d] + VF[d] + VS[d] + VB[d]) begin
                    mv[d] = 0;
                    mfrm[d] = mfrm[d] + 16'd1;
                    mam[d] = int'(m);
                end
            end
        end else begin
            ex[d].sol = 1'b0;
            ex[d].sof = 1'b0;
        end
    endtask

    task automatic compare(input int d);
        out_t a;
        if (d == 0) begin
            a.x = int'(if0.x); a.y = int'(if0.y); a.de = if0.de;
            a.hs = if0.hsync; a.vs = if0.vsync; a.sol = if0.sol;
            a.sof = if0.sof; a.rgb = {if0.red, if0.green, if0.blue};
            a.fc = if0.frame_cnt;
        end else begin
            a.x = int'(if1.x); a.y = int'(if1.y); a.de = if1.de;
            a.hs = if1.hsync; a.vs = if1.vsync; a.sol = if1.sol;
            a.sof = if1.sof; a.rgb = {if1.red, if1.green, if1.blue};
            a.fc = if1.frame_cnt;
        end
        check($sformatf("d%0d pos(x,y) cyc %0d", d, cyc_n),
              64'(a.x * 65536 + a.y), 64'(ex[d].x * 65536 + ex[d].y));
        check($sformatf("d%0d {de,hs,vs,sol,sof} cyc %0d", d, cyc_n),
              64'({a.de, a.hs, a.vs, a.sol, a.sof}),
              64'({ex[d].de, ex[d].hs, ex[d].vs, ex[d].sol, ex[d].sof}));
        check($sformatf("d%0d rgb cyc %0d", d, cyc_n), 64'(a.rgb), 64'(ex[d].rgb));
        check($sformatf("d%0d frame_cnt cyc %0d", d, cyc_n), 64'(a.fc), 64'(ex[d].fc));
    endtask

    task automatic cyc(input bit r, input bit c, input bit rs, input bit [1:0] m);
        @(negedge clk);
        cyc_n++;
        compare(0);
        compare(1);
        reset = r;
        if0.ce = c; if1.ce = c;
        if0.resync = rs; if1.resync = rs;
        if0.mode = m; if1.mode = m;
        model_step(0, r, c, rs, m);
        model_step(1, r, c, rs, m);
        if (r && !rst_prev) begin
            #1;
            compare(0);
            compare(1);
        end
        rst_prev = r;
    endtask

    initial begin
        bit [1:0] m;
        if0.ce = 1'b0; if1.ce = 1'b0;
        if0.resync = 1'b0; if1.resync = 1'b0;
        if0.mode = 2'd0; if1.mode = 2'd0;
        model_reset(0);
        model_reset(1);
        m = 2'd1;
        repeat (3) cyc(1'b1, 1'b0, 1'b0, m);
        for (int i = 0; i < 1000; i++) begin
            if (i % 137 == 100) m = 2'($urandom_range(0, 3));
            cyc(1'b0, 1'b1, 1'b0, m);
        end
        for (int i = 0; i < 1000; i++) begin
            if (i % 211 == 0) m = 2'($urandom_range(0, 3));
            cyc(1'b0, (i % 2) == 0, 1'b0, m);
        end
        for (int i = 0; i < 1500; i++) begin
            if (i % 97 == 0) m = 2'($urandom_range(0, 3));
            cyc(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 149) == 0, m);
        end
        for (int i = 0; i < 300; i++) cyc(1'b0, 1'b1, 1'b0, m);
        cyc(1'b0, 1'b1, 1'b1, 2'd2);
        for (int i = 0; i < 500; i++) cyc(1'b0, 1'b1, 1'b0, 2'd3);
        cyc(1'b1, 1'b1, 1'b0, m);
        repeat (2) cyc(1'b1, 1'b1, 1'b0, m);
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 0) m = 2'($urandom_range(0, 3));
            cyc(1'b0, 1'b1, 1'b0, m);
        end
        cyc(1'b0, 1'b0, 1'b0, m);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameters (name, default, meaning): H_ACTIVE 640 visible pixels; H_FP 16 h front porch; H_SYNC 96 h sync width; H_BP 48 h back porch; V_ACTIVE 480 visible lines; V_FP 10; V_SYNC 2; V_BP 33; HS_POL 1 hsync asserted level; VS_POL 1 vsync asserted level; CW 12 counter width.
REQ-002 Derived: H_TOTAL = sum of H params (800 default); V_TOTAL = sum of V params (525 default); BAR_W = H_ACTIVE/8 (integer).
REQ-003 Ports (name direction width meaning): clk in 1 pixel clock; reset in 1 async active-high reset; ce in 1 pixel advance enable; resync in 1 sync counter restart; mode in 2 pattern select; x out CW pixel column; y out CW line number; de out 1 display enable; hsync out 1; vsync out 1; red out 8; green out 8; blue out 8; sol out 1 start-of-line pulse; sof out 1 start-of-frame pulse; frame_cnt out 16 frame counter.
REQ-004 Single clock domain; reset asynchronous, active-high; all outputs registered.

Function
REQ-005 Internal counters hc (0..H_TOTAL-1), vc (0..V_TOTAL-1); advance only when ce=1; ce=0 holds counters and all outputs except sol/sof.
REQ-006 hc wraps H_TOTAL-1 -> 0; vc increments at hc wrap, wraps V_TOTAL-1 -> 0 when hc also wraps.
REQ-007 Latency 1: in cycle after a ce=1 cycle with (hc,vc)=(h,v), outputs x=h, y=v and de/hsync/vsync/rgb all correspond to (h,v); all aligned, no skew.
REQ-008 de = (hc < H_ACTIVE) && (vc < V_ACTIVE).
REQ-009 hsync = HS_POL when H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
REQ-010 vsync = VS_POL when V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL; changes only at hc=0 boundaries.
REQ-011 sol = 1 for exactly one cycle, coincident with outputs first showing x=0; sof likewise for x=0,y=0; both 0 during ce=0 hold cycles.
REQ-012 frame_cnt increments by 1 (mod 2^16) on each vc wrap V_TOTAL-1 -> 0; output updates with first (0,0) output.
REQ-013 mode sampled into active_mode only when counters advance into (0,0) or on resync; mid-frame mode changes take effect next frame.
REQ-014 rgb = 0 whenever de=0, regardless of mode.
REQ-015 active_mode 0: rgb = 000000.
REQ-016 active_mode 1: 8 vertical bars BAR_W wide; order white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000; bar index via in-line counter reset at hc=0, saturating at 7 (covers H_ACTIVE not multiple of 8); no divider.
REQ-017 active_mode 2: red = hc[7:0], green = vc[7:0], blue = frame_cnt[7:0].
REQ-018 active_mode 3: FFFFFF when hc[4:0]==0 or vc[4:0]==0, else 000000.
REQ-019 resync=1: next clock hc=0, vc=0, bar counter cleared, independent of ce; frame_cnt not incremented; outputs show (0,0) with sof=1 on following ce=1 advance.
REQ-020 resync and ce both high: resync wins; counters load 0, not 1.
REQ-021 Counters never exceed H_TOTAL-1 / V_TOTAL-1; CW must hold H_TOTAL-1 and V_TOTAL-1 (elaboration error otherwise).

Reset
REQ-022 reset=1 asynchronously: hc=0, vc=0, active_mode=0, bar counter=0, x=0, y=0, de=0, hsync=~HS_POL, vsync=~VS_POL, rgb=0, sol=0, sof=0, frame_cnt=0.
REQ-023 After reset release with ce=1, first output cycle shows (0,0), de=1, sol=1, sof=1.
REQ-024 Reset mid-frame discards position; no partial-frame frame_cnt increment.

Verification
REQ-025 Defaults, ce=1 constant, 2 frames: 800 clocks/line, 525 lines/frame, de high 640x480 per frame, hsync high x=656..751, vsync high y=490..491, frame_cnt 0->1->2.
REQ-026 HS_POL=0, VS_POL=0: hsync low x=656..751, high elsewhere; vsync low y=490..491; de unchanged.
REQ-027 ce toggled 1,0,1,0: line period 1600 clocks; sol/sof single-cycle; x sequence unchanged, no skips or repeats.
REQ-028 mode=1 set before frame: x=0..79 FFFFFF, 80..159 FFFF00, ..., 560..639 000000; H_ACTIVE=644 -> last bar 560..643 black; mode changed to 2 at y=100 -> bars persist until next frame.
REQ-029 resync at (x=300,y=200) with ce=1: next output (0,0), sof=1, frame_cnt unchanged; counting resumes normally.
REQ-030 reset asserted at (x=400,y=300) between clock edges: outputs immediately at REQ-022 values; release -> REQ-023 behaviour.
